// File: rtl/gx4000_asic_if.sv
// CPU-side bus bundle for the GX4000/Plus ASIC lock block.
interface gx4000_asic_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_data_out;

  modport master (
    output cpu_addr, cpu_data_in, cpu_wr, cpu_rd,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_wr, cpu_rd,
    output cpu_data_out
  );
endinterface

// File: rtl/gx4000_asic.sv
// Amstrad Plus/GX4000 ASIC unlock detector, key/challenge regs, RGB gate.
// Optional cartridge checksum at 00EF: define GX4000_CART_CHECKSUM_EN.
module gx4000_asic (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        gx4000_mode,
  input  logic        plus_mode,
  input  logic        force_unlock,
  gx4000_asic_if.slave bus,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  input  logic        hblank,
  input  logic        vblank,
  output logic [1:0]  r_out,
  output logic [1:0]  g_out,
  output logic [1:0]  b_out,
  input  logic        palette_wr,
  input  logic [3:0]  palette_addr,
  input  logic [23:0] palette_data,
  input  logic        cart_download,
  input  logic [24:0] cart_addr,
  input  logic [7:0]  cart_data,
  input  logic        cart_wr,
  output logic        asic_valid,
  output logic [7:0]  asic_status
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHALLENGE = 2'd1,
    RESPONSE  = 2'd2,
    VALID     = 2'd3
  } state_t;

  function automatic logic [7:0] seq_byte(
    input logic [4:0] i
  );
    case (i)
      5'd0:    seq_byte = 8'hFF;
      5'd1:    seq_byte = 8'h00;
      5'd2:    seq_byte = 8'hFF;
      5'd3:    seq_byte = 8'h77;
      5'd4:    seq_byte = 8'hB3;
      5'd5:    seq_byte = 8'h51;
      5'd6:    seq_byte = 8'hA8;
      5'd7:    seq_byte = 8'hD4;
      5'd8:    seq_byte = 8'h62;
      5'd9:    seq_byte = 8'h39;
      5'd10:   seq_byte = 8'h9C;
      5'd11:   seq_byte = 8'h46;
      5'd12:   seq_byte = 8'h2B;
      5'd13:   seq_byte = 8'h15;
      5'd14:   seq_byte = 8'h8A;
      5'd15:   seq_byte = 8'hCD;
      5'd16:   seq_byte = 8'hEE;
      default: seq_byte = 8'h00;
    endcase
  endfunction

  logic            asic_locked;
  logic [4:0]      seq_idx;
  state_t          state;
  logic [7:0]      key;
  logic [3:0][7:0] challenge;
  logic            cpu_wr_q;
  logic [7:0]      checksum_rd;
  logic [7:0]      rd_val;

  logic wr_ev, crtc_ev, reg_sel, seq_hit;

  assign wr_ev   = bus.cpu_wr & ~cpu_wr_q;
  assign reg_sel = bus.cpu_addr[15:4] == 12'h00E;
  assign crtc_ev = wr_ev & (bus.cpu_addr[15:8] == 8'hBC)
                 & bus.cpu_addr[0] & (gx4000_mode | plus_mode);
  assign seq_hit = bus.cpu_data_in == seq_byte(seq_idx);

  assign asic_status = {asic_locked, gx4000_mode, plus_mode,
                        3'b000, state};
  assign asic_valid  = ~asic_locked & (state != IDLE);

  assign r_out = (hblank | vblank) ? 2'd0 : r_in;
  assign g_out = (hblank | vblank) ? 2'd0 : g_in;
  assign b_out = (hblank | vblank) ? 2'd0 : b_in;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cpu_wr_q    <= 1'b0;
      asic_locked <= 1'b1;
      seq_idx     <= 5'd0;
    end else begin
      cpu_wr_q <= bus.cpu_wr;
      if (crtc_ev) begin
        if (seq_hit && seq_idx == 5'd16)
          seq_idx <= 5'd0;
        else if (seq_hit)
          seq_idx <= seq_idx + 5'd1;
        else
          seq_idx <= (bus.cpu_data_in == 8'hFF) ? 5'd1 : 5'd0;
      end
      if (force_unlock || (crtc_ev && seq_hit && seq_idx == 5'd16))
        asic_locked <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= IDLE;
      key       <= 8'h00;
      challenge <= '0;
    end else if (wr_ev && reg_sel && !asic_locked) begin
      unique case (1'b1)
        bus.cpu_addr[3:2] == 2'b00:
          challenge[bus.cpu_addr[1:0]] <= bus.cpu_data_in;
        bus.cpu_addr[3:0] == 4'h5:
          key <= bus.cpu_data_in;
        bus.cpu_addr[3:0] == 4'h9:
          state <= state_t'(bus.cpu_data_in[1:0]);
        default: ;
      endcase
    end
  end

`ifdef GX4000_CART_CHECKSUM_EN
  logic [7:0] checksum;
  logic       cart_wr_q;
  logic       cart_dl_q;
  logic       cart_ev;

  assign cart_ev     = cart_wr & ~cart_wr_q & cart_download;
  assign checksum_rd = checksum;

  // A download start restarts the sum, keeping a byte landing that same cycle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      checksum  <= 8'h00;
      cart_wr_q <= 1'b0;
      cart_dl_q <= 1'b0;
    end else begin
      cart_wr_q <= cart_wr;
      cart_dl_q <= cart_download;
      if (cart_download && !cart_dl_q)
        checksum <= cart_ev ? cart_data : 8'h00;
      else if (cart_ev)
        checksum <= checksum + cart_data;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{palette_wr, palette_addr,
                       palette_data, cart_addr};
`else
  assign checksum_rd = 8'h00;

  logic unused_ok;
  assign unused_ok = ^{palette_wr, palette_addr, palette_data,
                       cart_addr, cart_download, cart_data, cart_wr};
`endif

  always_comb begin
    rd_val = 8'hFF;
    if (!asic_locked && reg_sel) begin
      case (bus.cpu_addr[3:0])
        4'h0, 4'h1, 4'h2, 4'h3:
          rd_val = challenge[bus.cpu_addr[1:0]];
        4'h5: rd_val = key;
        4'h9: rd_val = {6'b0, state};
        4'hA, 4'hB, 4'hC, 4'hD:
          rd_val = challenge[bus.cpu_addr[1:0] + 2'd2] ^ key;
        4'hE: rd_val = asic_status;
        4'hF: rd_val = checksum_rd;
        default: rd_val = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      bus.cpu_data_out <= 8'hFF;
    else if (bus.cpu_rd)
      bus.cpu_data_out <= rd_val;
  end

endmodule

// File: tb/tb_gx4000_asic.sv
// Scoreboard bench for gx4000_asic: directed vectors, queued expectations,
// a negedge monitor that pops and compares.
module tb_gx4000_asic;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        gx4000_mode, plus_mode, force_unlock;
  logic [1:0]  r_in, g_in, b_in, r_out, g_out, b_out;
  logic        hblank, vblank;
  logic        palette_wr;
  logic [3:0]  palette_addr;
  logic [23:0] palette_data;
  logic        cart_download, cart_wr;
  logic [24:0] cart_addr;
  logic [7:0]  cart_data;
  logic        asic_valid;
  logic [7:0]  asic_status;

  gx4000_asic_if bus ();

  gx4000_asic dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .gx4000_mode(gx4000_mode), .plus_mode(plus_mode),
    .force_unlock(force_unlock), .bus(bus),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hblank(hblank), .vblank(vblank),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .palette_wr(palette_wr), .palette_addr(palette_addr),
    .palette_data(palette_data),
    .cart_download(cart_download), .cart_addr(cart_addr),
    .cart_data(cart_data), .cart_wr(cart_wr),
    .asic_valid(asic_valid), .asic_status(asic_status)
  );

  always #5 clk_sys = ~clk_sys;

  // sel: 0 status, 1 valid, 2 data_out, 3 r_out, 4 g_out, 5 b_out
  int         sel_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  logic [7:0] seq [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51,
                           8'hA8, 8'hD4, 8'h62, 8'h39, 8'h9C, 8'h46,
                           8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};

  task automatic expect_val(input int sel, input logic [7:0] v,
                            input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      0: observe = asic_status;
      1: observe = {7'b0, asic_valid};
      2: observe = bus.cpu_data_out;
      3: observe = {6'b0, r_out};
      4: observe = {6'b0, g_out};
      default: observe = {6'b0, b_out};
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk_sys);
      while (sel_q.size() > 0) begin
        int         s;
        logic [7:0] e, a;
        string      nm;
        s  = sel_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = observe(s);
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %02h expected %02h", nm, a, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr    = a;
    bus.cpu_data_in = d;
    bus.cpu_wr      = 1'b1;
    tick();
    bus.cpu_wr      = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [7:0] e,
                        input string nm);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    tick();
    bus.cpu_rd   = 1'b0;
    expect_val(2, e, nm);
    tick();
  endtask

  task automatic send_seq(input int upto, input logic [7:0] sub4);
    for (int i = 0; i < upto; i++)
      bus_wr(16'hBC01, (i == 4) ? sub4 : seq[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; gx4000_mode = 1'b1; plus_mode = 1'b0;
    force_unlock = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_data_in = 8'h00;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    r_in = 2'd0; g_in = 2'd0; b_in = 2'd0;
    hblank = 1'b0; vblank = 1'b0;
    palette_wr = 1'b0; palette_addr = 4'h0; palette_data = 24'h0;
    cart_download = 1'b0; cart_addr = 25'h0;
    cart_data = 8'h00; cart_wr = 1'b0;

    do_reset();
    expect_val(0, 8'hC0, "reset_status");
    expect_val(1, 8'h00, "reset_valid");
    expect_val(2, 8'hFF, "reset_dout");
    tick();

    bus_wr(16'hBC01, 8'h00);
    send_seq(16, 8'hB3);
    expect_val(0, 8'hC0, "seq16_locked");
    tick();
    bus_wr(16'hBC01, 8'hEE);
    expect_val(0, 8'h40, "seq_unlock");
    tick();

    do_reset();
    send_seq(17, 8'h7A);
    expect_val(0, 8'hC0, "bad_seq_locked");
    tick();
    bus_wr(16'hBC00, 8'hFF);
    send_seq(17, 8'hB3);
    expect_val(0, 8'h40, "resync_unlock");
    tick();

    do_reset();
    expect_val(0, 8'hC0, "reset_relock");
    force_unlock = 1'b1;
    tick();
    expect_val(0, 8'h40, "force_unlock");
    force_unlock = 1'b0;
    tick();
    tick();
    expect_val(0, 8'h40, "force_persist");
    tick();

    bus_wr(16'h00E5, 8'h42);
    expect_val(1, 8'h00, "valid_idle");
    tick();
    bus_wr(16'h00E9, 8'h01);
    expect_val(1, 8'h01, "valid_set");
    expect_val(0, 8'h41, "status_port");
    tick();
    bus_rd(16'h00EE, 8'h41, "rd_status");
    bus_rd(16'h00EA, 8'h42, "rd_resp0");
    bus_wr(16'h00E0, 8'h13);
    bus_wr(16'h00E3, 8'hF0);
    bus_rd(16'h00EA, 8'h51, "rd_resp0_b");
    bus_rd(16'h00ED, 8'hB2, "rd_resp3");
    bus_rd(16'h00E3, 8'hF0, "rd_chal3");
    bus_rd(16'h00E5, 8'h42, "rd_key");
    bus_rd(16'h00E9, 8'h01, "rd_state");
    bus_rd(16'h00E4, 8'hFF, "rd_unmapped");
    bus.cpu_addr = 16'h00E5;
    tick();
    expect_val(2, 8'hFF, "dout_hold");
    tick();

    cart_download = 1'b1;
    tick();
    foreach (seq[i]) begin
      if (i < 3) begin
        cart_data = (i == 0) ? 8'h80 : (i == 1) ? 8'h90 : 8'h05;
        cart_wr = 1'b1;
        tick();
        cart_wr = 1'b0;
        tick();
      end
    end
    cart_download = 1'b0;
`ifdef GX4000_CART_CHECKSUM_EN
    bus_rd(16'h00EF, 8'h15, "rd_checksum");
`else
    bus_rd(16'h00EF, 8'h00, "rd_checksum");
`endif

    do_reset();
    bus_wr(16'h00E9, 8'h01);
    expect_val(1, 8'h00, "locked_valid");
    expect_val(0, 8'hC0, "locked_status");
    tick();
    bus_rd(16'h00EE, 8'hFF, "locked_rd_ee");
    bus_rd(16'h00E5, 8'hFF, "locked_rd_key");

    r_in = 2'd3; g_in = 2'd2; b_in = 2'd1; hblank = 1'b1;
    #1;
    expect_val(3, 8'h00, "hblank_r");
    tick();
    hblank = 1'b0;
    #1;
    expect_val(3, 8'h03, "pass_r");
    expect_val(4, 8'h02, "pass_g");
    expect_val(5, 8'h01, "pass_b");
    tick();
    vblank = 1'b1;
    #1;
    expect_val(5, 8'h00, "vblank_b");
    tick();
    vblank = 1'b0;

    gx4000_mode = 1'b0; plus_mode = 1'b0;
    do_reset();
    send_seq(17, 8'hB3);
    expect_val(0, 8'h80, "nomode_locked");
    tick();

    plus_mode = 1'b1;
    bus_wr(16'hBC01, 8'h00);
    send_seq(17, 8'hB3);
    expect_val(0, 8'h20, "plus_unlock");
    tick();
    tick();

    if (sel_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
